// File: rtl/dir_detect_pkg.sv
// dir_detect_pkg
//   Shared types and helpers for the N-sensor passage-direction detector.
//   - state_e  : sweep FSM state (IDLE / FWD / REV)
//   - DIR_FWD / DIR_REV : encoding of the latched direction output
//   - cntW()   : register width needed to hold values 0..n-1 (min 1 bit)
package dir_detect_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      REV  = 2'd2
   } state_e;

   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_REV = 1'b0;

   function automatic int cntW(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ir_debounce.sv
// ir_debounce
//   Conditions one active-low IR sensor: 2-FF synchroniser, stability
//   debouncer and a one-cycle pulse on each accepted 1->0 transition.
// Ports:
//   CLK    in  clock
//   RSTn   in  asynchronous active-low reset
//   irRaw  in  raw sensor level (0 = beam broken)
//   hit    out one-cycle pulse when the debounced level falls
// Latency from a raw edge to hit is 2 + DEB_CYC cycles.
module ir_debounce
   import dir_detect_pkg::*;
#(
   parameter int DEB_CYC = 2
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic irRaw,
   output logic hit
);

   localparam int CW = cntW(DEB_CYC);

   logic [1:0]    syncQ;
   logic [CW-1:0] stab;
   logic          levelQ;
   logic          levelD;

   // stab counts consecutive cycles the synchronised input disagrees with
   // the accepted level; the level flips on the DEB_CYC-th such cycle.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         syncQ  <= 2'b11;
         stab   <= '0;
         levelQ <= 1'b1;
         levelD <= 1'b1;
      end else begin
         syncQ  <= {syncQ[0], irRaw};
         levelD <= levelQ;
         if (syncQ[1] == levelQ) begin
            stab <= '0;
         end else if (stab == CW'(DEB_CYC - 1)) begin
            levelQ <= syncQ[1];
            stab   <= '0;
         end else begin
            stab <= stab + CW'(1);
         end
      end
   end

   assign hit = levelD & ~levelQ;

endmodule

// File: rtl/dir_detect_n.sv
// dir_detect_n
//   N-sensor passage-direction detector. Tracks an ordered sweep across all
//   sensors (0..N-1 forward, N-1..0 reverse), latches the direction, enables
//   the motor after the first pass and keeps saturating pass counters.
// Ports:
//   CLK        in  clock
//   RSTn       in  asynchronous active-low reset
//   IR         in  [N_SENS] raw sensors, active low
//   SW         in  detector / motor enable switch
//   dir        out direction of last completed pass (1 = forward)
//   en         out motor enable (SW & a pass has been seen since reset)
//   evt_valid  out one-cycle pulse on pass completion
//   err        out one-cycle pulse on sequence error or timeout
//   busy       out sweep in progress
//   fwd_cnt    out [CNT_W] saturating forward pass count
//   rev_cnt    out [CNT_W] saturating reverse pass count
module dir_detect_n
   import dir_detect_pkg::*;
#(
   parameter int N_SENS  = 3,
   parameter int DEB_CYC = 2,
   parameter int TMO_CYC = 1000,
   parameter int CNT_W   = 8
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [N_SENS-1:0] IR,
   input  logic              SW,
   output logic              dir,
   output logic              en,
   output logic              evt_valid,
   output logic              err,
   output logic              busy,
   output logic [CNT_W-1:0]  fwd_cnt,
   output logic [CNT_W-1:0]  rev_cnt
);

   localparam int IW = cntW(N_SENS);
   localparam int TW = cntW(TMO_CYC + 1);

   logic [N_SENS-1:0] hit;

   for (genvar i = 0; i < N_SENS; i++) begin : g_deb
      ir_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
         .CLK   (CLK),
         .RSTn  (RSTn),
         .irRaw (IR[i]),
         .hit   (hit[i])
      );
   end

   state_e           state, stateN;
   logic [IW-1:0]    idx, idxN;
   logic [TW-1:0]    tmo, tmoN;
   logic             passSeen, passN;
   logic             dirN, evtN, errN;
   logic [CNT_W-1:0] fwdN, revN;

   int numHits;
   int hitIdx;

   always_comb begin
      numHits = 0;
      hitIdx  = 0;
      for (int i = 0; i < N_SENS; i++) begin
         if (hit[i]) begin
            numHits = numHits + 1;
            hitIdx  = i;
         end
      end
   end

   logic isFwd;
   int   idxI, endIdx, prevIdx;

   always_comb begin
      stateN  = state;
      idxN    = idx;
      tmoN    = tmo;
      passN   = passSeen;
      dirN    = dir;
      evtN    = 1'b0;
      errN    = 1'b0;
      fwdN    = fwd_cnt;
      revN    = rev_cnt;
      isFwd   = (state == FWD);
      idxI    = int'(idx);
      endIdx  = isFwd ? N_SENS - 1 : 0;
      // sensor just passed: a re-trigger on it is harmless
      prevIdx = isFwd ? idxI - 1 : idxI + 1;

      if (!SW) begin
         stateN = IDLE;
         tmoN   = '0;
      end else begin
         case (state)
            IDLE: begin
               tmoN = '0;
               if (numHits > 1) begin
                  errN = 1'b1;
               end else if (numHits == 1) begin
                  if (hitIdx == 0) begin
                     stateN = FWD;
                     idxN   = IW'(1);
                  end else if (hitIdx == N_SENS - 1) begin
                     stateN = REV;
                     idxN   = IW'(N_SENS - 2);
                  end
               end
            end
            FWD, REV: begin
               // hit decisions are checked ahead of the timeout so a hit on
               // the expiry cycle still counts
               if (numHits > 1) begin
                  errN   = 1'b1;
                  stateN = IDLE;
               end else if (numHits == 1 && hitIdx == idxI) begin
                  tmoN = '0;
                  if (idxI == endIdx) begin
                     stateN = IDLE;
                     evtN   = 1'b1;
                     passN  = 1'b1;
                     if (isFwd) begin
                        dirN = DIR_FWD;
                        if (!(&fwd_cnt)) fwdN = fwd_cnt + CNT_W'(1);
                     end else begin
                        dirN = DIR_REV;
                        if (!(&rev_cnt)) revN = rev_cnt + CNT_W'(1);
                     end
                  end else begin
                     idxN = isFwd ? idx + IW'(1) : idx - IW'(1);
                  end
               end else if (numHits == 1 && hitIdx != prevIdx) begin
                  errN   = 1'b1;
                  stateN = IDLE;
               end else if (tmo == TW'(TMO_CYC)) begin
                  errN   = 1'b1;
                  stateN = IDLE;
               end else begin
                  tmoN = tmo + TW'(1);
               end
            end
            default: stateN = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= IDLE;
         idx       <= '0;
         tmo       <= '0;
         passSeen  <= 1'b0;
         dir       <= DIR_REV;
         en        <= 1'b0;
         evt_valid <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         fwd_cnt   <= '0;
         rev_cnt   <= '0;
      end else begin
         state     <= stateN;
         idx       <= idxN;
         tmo       <= tmoN;
         passSeen  <= passN;
         dir       <= dirN;
         en        <= SW & passN;
         evt_valid <= evtN;
         err       <= errN;
         busy      <= (stateN != IDLE);
         fwd_cnt   <= fwdN;
         rev_cnt   <= revN;
      end
   end

endmodule

// File: tb/tb_dir_detect_n.sv
module tb_dir_detect_n;

   logic       CLK;
   logic       RSTn;
   logic [2:0] irA;
   logic       swA;
   logic       dirA, enA, evtA, errA, busyA;
   logic [7:0] fwdA, revA;
   logic [4:0] irB;
   logic       swB;
   logic       dirB, enB, evtB, errB, busyB;
   logic [1:0] fwdB, revB;

   int nChk  = 0;
   int nFail = 0;

   dir_detect_n #(.N_SENS(3), .DEB_CYC(2), .TMO_CYC(20), .CNT_W(8)) dutA (
      .CLK(CLK), .RSTn(RSTn), .IR(irA), .SW(swA),
      .dir(dirA), .en(enA), .evt_valid(evtA), .err(errA), .busy(busyA),
      .fwd_cnt(fwdA), .rev_cnt(revA)
   );

   dir_detect_n #(.N_SENS(5), .DEB_CYC(2), .TMO_CYC(20), .CNT_W(2)) dutB (
      .CLK(CLK), .RSTn(RSTn), .IR(irB), .SW(swB),
      .dir(dirB), .en(enB), .evt_valid(evtB), .err(errB), .busy(busyB),
      .fwd_cnt(fwdB), .rev_cnt(revB)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // pulse counters and busy-rise / err timestamps for dutA
   int   cyc = 0, nEvtA = 0, nErrA = 0, nEvtB = 0, riseCyc = 0, errCyc = 0;
   logic busyPrevA = 1'b0;
   always @(negedge CLK) begin
      cyc <= cyc + 1;
      if (evtA) nEvtA <= nEvtA + 1;
      if (errA) begin nErrA <= nErrA + 1; errCyc <= cyc; end
      if (evtB) nEvtB <= nEvtB + 1;
      if (busyA && !busyPrevA) riseCyc <= cyc;
      busyPrevA <= busyA;
   end

   task automatic pulseA(input int s);
      @(negedge CLK); irA[s] = 1'b0;
      repeat (3) @(negedge CLK);
      irA[s] = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   task automatic sweepA(input bit fwd);
      for (int i = 0; i < 3; i++) pulseA(fwd ? i : 2 - i);
      repeat (4) @(negedge CLK);
   endtask

   task automatic pulseB(input int s);
      @(negedge CLK); irB[s] = 1'b0;
      repeat (3) @(negedge CLK);
      irB[s] = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_reset();
      nChk++; if ({dirA, enA, evtA, errA, busyA} !== 5'b0) begin nFail++; $display("FAIL reset_flags_A got=%b exp=00000", {dirA, enA, evtA, errA, busyA}); end
      nChk++; if ({fwdA, revA} !== 16'h0) begin nFail++; $display("FAIL reset_cnt_A got=%h exp=0000", {fwdA, revA}); end
      nChk++; if ({dirB, enB, busyB, fwdB, revB} !== 7'b0) begin nFail++; $display("FAIL reset_B got=%b exp=0000000", {dirB, enB, busyB, fwdB, revB}); end
   endtask

   task automatic test_forward();
      int e0;
      e0 = nEvtA;
      sweepA(1'b1);
      nChk++; if (nEvtA - e0 !== 1) begin nFail++; $display("FAIL fwd_evt got=%0d exp=1", nEvtA - e0); end
      nChk++; if (dirA !== 1'b1) begin nFail++; $display("FAIL fwd_dir got=%b exp=1", dirA); end
      nChk++; if (fwdA !== 8'd1) begin nFail++; $display("FAIL fwd_cnt got=%0d exp=1", fwdA); end
      nChk++; if (enA !== 1'b1) begin nFail++; $display("FAIL fwd_en got=%b exp=1", enA); end
      nChk++; if (busyA !== 1'b0) begin nFail++; $display("FAIL fwd_busy got=%b exp=0", busyA); end
   endtask

   task automatic test_reverse();
      int e0;
      e0 = nEvtA;
      sweepA(1'b0);
      nChk++; if (nEvtA - e0 !== 1) begin nFail++; $display("FAIL rev_evt got=%0d exp=1", nEvtA - e0); end
      nChk++; if (dirA !== 1'b0) begin nFail++; $display("FAIL rev_dir got=%b exp=0", dirA); end
      nChk++; if (revA !== 8'd1) begin nFail++; $display("FAIL rev_cnt got=%0d exp=1", revA); end
      nChk++; if (fwdA !== 8'd1) begin nFail++; $display("FAIL rev_fwd_hold got=%0d exp=1", fwdA); end
   endtask

   task automatic test_glitch();
      int  r0, e0;
      bit  sawBusy;
      r0 = nErrA; e0 = nEvtA; sawBusy = 1'b0;
      @(negedge CLK); irA[0] = 1'b0;
      @(negedge CLK); irA[0] = 1'b1;
      repeat (8) begin @(negedge CLK); if (busyA) sawBusy = 1'b1; end
      nChk++; if (sawBusy !== 1'b0) begin nFail++; $display("FAIL glitch_busy got=%b exp=0", sawBusy); end
      // middle sensor alone from IDLE is ignored
      pulseA(1);
      repeat (4) @(negedge CLK);
      nChk++; if ({busyA, 8'(nErrA - r0)} !== 9'd0) begin nFail++; $display("FAIL mid_ignore got=%b/%0d exp=0/0", busyA, nErrA - r0); end
      pulseA(0);
      pulseA(2);
      repeat (4) @(negedge CLK);
      nChk++; if (nErrA - r0 !== 1) begin nFail++; $display("FAIL order_err got=%0d exp=1", nErrA - r0); end
      nChk++; if (busyA !== 1'b0) begin nFail++; $display("FAIL order_busy got=%b exp=0", busyA); end
      nChk++; if ({fwdA, revA} !== {8'd1, 8'd1} || nEvtA != e0) begin nFail++; $display("FAIL order_cnt got=%0d/%0d evt=%0d exp=1/1 evt=0", fwdA, revA, nEvtA - e0); end
   endtask

   task automatic test_timeout();
      int r0;
      r0 = nErrA;
      pulseA(0);
      nChk++; if (busyA !== 1'b1) begin nFail++; $display("FAIL tmo_busy_start got=%b exp=1", busyA); end
      repeat (30) @(negedge CLK);
      nChk++; if (nErrA - r0 !== 1) begin nFail++; $display("FAIL tmo_err got=%0d exp=1", nErrA - r0); end
      nChk++; if (errCyc - riseCyc !== 21) begin nFail++; $display("FAIL tmo_delay got=%0d exp=21", errCyc - riseCyc); end
      nChk++; if (busyA !== 1'b0) begin nFail++; $display("FAIL tmo_busy got=%b exp=0", busyA); end
      sweepA(1'b1);
      nChk++; if ({dirA, fwdA} !== {1'b1, 8'd2}) begin nFail++; $display("FAIL tmo_after got=%b/%0d exp=1/2", dirA, fwdA); end
   endtask

   task automatic test_disable();
      int e0, r0;
      e0 = nEvtA; r0 = nErrA;
      swA = 1'b0;
      sweepA(1'b0);
      nChk++; if (nEvtA - e0 !== 0) begin nFail++; $display("FAIL dis_evt got=%0d exp=0", nEvtA - e0); end
      nChk++; if (enA !== 1'b0) begin nFail++; $display("FAIL dis_en got=%b exp=0", enA); end
      nChk++; if ({dirA, fwdA, revA} !== {1'b1, 8'd2, 8'd1}) begin nFail++; $display("FAIL dis_hold got=%b/%0d/%0d exp=1/2/1", dirA, fwdA, revA); end
      nChk++; if (nErrA - r0 !== 0) begin nFail++; $display("FAIL dis_err got=%0d exp=0", nErrA - r0); end
      swA = 1'b1;
      @(negedge CLK); irA[0] = 1'b0; irA[2] = 1'b0;
      repeat (3) @(negedge CLK);
      irA[0] = 1'b1; irA[2] = 1'b1;
      repeat (6) @(negedge CLK);
      nChk++; if (nErrA - r0 !== 1) begin nFail++; $display("FAIL simul_err got=%0d exp=1", nErrA - r0); end
      nChk++; if ({busyA, enA} !== 2'b01) begin nFail++; $display("FAIL simul_state got=%b exp=01", {busyA, enA}); end
   endtask

   task automatic test_saturation();
      int e0;
      e0 = nEvtB;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 5; i++) pulseB(i);
         repeat (4) @(negedge CLK);
      end
      nChk++; if (nEvtB - e0 !== 5) begin nFail++; $display("FAIL sat_evt got=%0d exp=5", nEvtB - e0); end
      nChk++; if (fwdB !== 2'd3) begin nFail++; $display("FAIL sat_cnt got=%0d exp=3", fwdB); end
      nChk++; if ({dirB, enB} !== 2'b11) begin nFail++; $display("FAIL sat_dir_en got=%b exp=11", {dirB, enB}); end
      pulseB(0);
      pulseB(1);
      nChk++; if (busyB !== 1'b1) begin nFail++; $display("FAIL mid_busy got=%b exp=1", busyB); end
      #2 RSTn = 1'b0;
      #1;
      nChk++; if ({dirB, enB, evtB, errB, busyB} !== 5'b0) begin nFail++; $display("FAIL rst_mid_flags got=%b exp=00000", {dirB, enB, evtB, errB, busyB}); end
      nChk++; if ({fwdB, revB} !== 4'b0) begin nFail++; $display("FAIL rst_mid_cnt got=%b exp=0000", {fwdB, revB}); end
      @(negedge CLK); RSTn = 1'b1;
   endtask

   initial begin
      RSTn = 1'b0;
      irA  = '1;
      irB  = '1;
      swA  = 1'b1;
      swB  = 1'b1;
      repeat (3) @(negedge CLK);
      test_reset();
      RSTn = 1'b1;
      repeat (2) @(negedge CLK);
      test_forward();
      test_reverse();
      test_glitch();
      test_timeout();
      test_disable();
      test_saturation();
      repeat (2) @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", nChk, nFail);
      $finish;
   end

endmodule

// File: doc/dir_detect_n.md
# dir_detect_n

Parametrised N-sensor passage-direction detector for the motor test path. Each of N_SENS active-low IR sensors is synchronised and debounced. The block tracks an ordered sweep across all sensors: forward is sensor 0 to N_SENS-1, reverse is N_SENS-1 to 0. On a complete sweep it latches the direction, raises the motor enable, and counts passes per direction. Over the three-sensor direction tester it adds arbitrary sensor count, debounce, inter-sensor timeout, error reporting and pass counters.

## Interface
Parameters:
- N_SENS, 3, number of IR sensors; legal values are 2 and above.
- DEB_CYC, 2, consecutive stable cycles required to accept a level change; legal values are 1 and above.
- TMO_CYC, 1000, maximum cycles between consecutive accepted sensor hits.
- CNT_W, 8, width of each pass counter.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock.
- RSTn  in  1  asynchronous active-low reset.
- IR  in  N_SENS  raw sensor inputs, active low (0 = beam broken).
- SW  in  1  detector/motor enable switch.
- dir  out  1  direction of last completed pass (1 = forward).
- en  out  1  motor enable.
- evt_valid  out  1  one-cycle pulse on pass completion.
- err  out  1  one-cycle pulse on a sequence error or timeout.
- busy  out  1  high while a sweep is in progress.
- fwd_cnt  out  CNT_W  saturating count of forward passes.
- rev_cnt  out  CNT_W  saturating count of reverse passes.

## Operation
- **Input conditioning, per sensor:**
  - 2-FF synchroniser, then the debouncer.
  - The debounced level takes a new value only after DEB_CYC consecutive cycles of that value; the debounced level resets to 1.
  - hit[i] is a one-cycle pulse on a debounced 1→0 transition.
- **States:** IDLE, FWD, REV. A step index idx tracks the next expected sensor.
- **IDLE:**
  - Single hit on 0 → FWD, idx=1.
  - Single hit on N_SENS-1 → REV, idx=N_SENS-2.
  - Hits on middle sensors are ignored with no err.
- **FWD/REV, per accepted hit:**
  - A single hit on idx advances idx by one (FWD) or back by one (REV). The timeout counter reloads.
  - A hit on the sensor just passed (re-trigger) is ignored.
  - A hit on the terminal sensor (N_SENS-1 in FWD, 0 in REV) completes the pass:
    - evt_valid pulses and dir updates.
    - fwd_cnt or rev_cnt increments, saturating at all ones.
    - The FSM returns to IDLE.
  - Any other hit, or two or more hits in the same cycle → err pulse, IDLE, counters unchanged.
- **Timeout:** TMO_CYC cycles with no accepted hit while in FWD/REV → err pulse, IDLE.
- **Simultaneous hits in IDLE:** two or more hits in the same cycle → err pulse, stay in IDLE.
- **Outputs:**
  - busy = (state != IDLE).
  - en = SW & pass_seen, where pass_seen is set by the first completed pass after reset.
  - dir holds its value between passes.
- **SW = 0:**
  - FSM forced to IDLE synchronously; no evt_valid or err pulses.
  - en = 0; counters and dir hold.
  - The debouncers keep running.
- **Reset values:** state=IDLE, dir=0, en=0, evt_valid=0, err=0, busy=0, fwd_cnt=0, rev_cnt=0, pass_seen=0.

## Timing
- From a raw IR edge to hit[i]: 2 + DEB_CYC cycles.
- From hit[i] to the FSM reaction (state, busy, evt_valid, err, dir, counters): 1 cycle. All outputs are registered.
- Minimum raw low pulse that registers: DEB_CYC cycles.
- The timeout counter counts cycles after the most recent accepted hit. err is asserted on the cycle the count reaches TMO_CYC.
- If a hit and the timeout coincide on the same cycle, the hit wins.
- If SW falls on the completing-hit cycle, SW wins: no event.
- RSTn assertion mid-sweep clears everything immediately. The sweep is lost.

## Structure
- Package dir_detect_pkg holds:
  - the state enum (IDLE/FWD/REV);
  - the DIR_FWD=1 and DIR_REV=0 constants;
  - a clog2-based width function for idx and the timeout counter.
- Sub-module ir_debounce (parameter DEB_CYC) contains the synchroniser, the debouncer and the falling-edge pulse. It is instantiated N_SENS times in a generate loop.
- The top level contains the FSM, timeout counter, pass counters and output registers.

## Test plan
1. **Forward sweep.** N_SENS=3, DEB_CYC=2. Pulse IR[0], IR[1], IR[2] low for 3 cycles each, 2 cycles apart. Required: evt_valid once, dir=1, fwd_cnt=1, en=1 with SW=1.
2. **Reverse sweep.** Pulse IR[2], IR[1], IR[0]. Required: dir=0, rev_cnt=1, fwd_cnt unchanged.
3. **Glitch filtering.** Apply a 1-cycle low glitch on IR[0]. Required: no hit, busy stays 0. Then apply an out-of-order sweep 0, 2. Required: err pulse, IDLE, no counter change.
4. **Timeout.** TMO_CYC=20. Hit IR[0] only, wait 25 cycles. Required: err exactly 21 cycles after busy rises, busy=0. A following full sweep still counts.
5. **Disable and simultaneous hits.** With SW=0, run a full sweep. Required: no evt_valid, en=0. With SW=1, hit IR[0] and IR[2] in the same cycle from IDLE. Required: err pulse.
6. **Saturation and reset.** CNT_W=2, N_SENS=5. Run 5 forward sweeps. Required: fwd_cnt=3. Assert RSTn low mid-sweep. Required: all outputs return to their reset values.
